// File: rtl/cdc_handshake_tx_pkg.sv
// cdc_pkg: shared types and default constants for the 4-phase REQ/ACK crossing.
//   cdc_state_e        - transmitter states (IDLE, REQ_HIGH, REQ_LOW)
//   CDC_DATA_WIDTH     - default transferred word width
//   CDC_SYNC_STAGES    - default ACK synchronizer depth (legal 2..4)
//   CDC_TIMEOUT_CYCLES - default REQ_HIGH wait limit, 0 disables the timeout
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ_HIGH = 2'd1,
    REQ_LOW  = 2'd2
  } cdc_state_e;

  localparam int CDC_DATA_WIDTH     = 32;
  localparam int CDC_SYNC_STAGES    = 2;
  localparam int CDC_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/cdc_handshake_tx_level_sync.sv
// level_sync: multi-flop synchronizer for a slowly changing level.
//   CLK   - destination clock of the synchronized level
//   RESET - asynchronous active-high clear of the whole chain
//   d     - asynchronous level input
//   q     - synchronized level, STAGES cycles of latency
module level_sync #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source-side transmitter of a 4-phase REQ/ACK crossing.
// Captures a word on an accepted SEND_I, raises REQ_O, waits for the
// synchronized ACK to rise (or a timeout), drops REQ_O and then waits for
// ACK to fall before returning to idle.
//   CLK, RESET   - source clock, asynchronous active-high reset
//   SEND_I       - one-cycle strobe, accepted only while READY_O=1
//   DATA_I       - word sampled on an accepted SEND_I
//   READY_O      - idle, SEND_I accepted this cycle
//   REQ_O        - registered request level towards the destination
//   DATA_O       - held word, stable while REQ_O=1
//   ACK_ASYNC_I  - destination acknowledge, asynchronous to CLK
//   DONE_O       - pulse: ACK seen high then low
//   TIMEOUT_O    - pulse: ACK not seen high within TIMEOUT_CYCLES
//   DROP_O       - pulse: SEND_I ignored because the block was busy
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH     = CDC_DATA_WIDTH,
  parameter int SYNC_STAGES    = CDC_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = CDC_TIMEOUT_CYCLES
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  SEND_I,
  input  logic [DATA_WIDTH-1:0] DATA_I,
  output logic                  READY_O,
  output logic                  REQ_O,
  output logic [DATA_WIDTH-1:0] DATA_O,
  input  logic                  ACK_ASYNC_I,
  output logic                  DONE_O,
  output logic                  TIMEOUT_O,
  output logic                  DROP_O
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  cdc_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             timed_out;  // current transfer abandoned, suppress DONE_O
  logic             ack_s;
  logic             timeout_hit;

  level_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .CLK   (CLK),
    .RESET (RESET),
    .d     (ACK_ASYNC_I),
    .q     (ack_s)
  );

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
  assign READY_O     = (state == IDLE);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      REQ_O     <= 1'b0;
      DATA_O    <= '0;
      DONE_O    <= 1'b0;
      TIMEOUT_O <= 1'b0;
      DROP_O    <= 1'b0;
      cnt       <= '0;
      timed_out <= 1'b0;
    end else begin
      DONE_O    <= 1'b0;
      TIMEOUT_O <= 1'b0;
      DROP_O    <= SEND_I && (state != IDLE);
      case (state)
        IDLE: begin
          if (SEND_I) begin
            DATA_O    <= DATA_I;
            REQ_O     <= 1'b1;
            cnt       <= '0;
            timed_out <= 1'b0;
            state     <= REQ_HIGH;
          end
        end
        REQ_HIGH: begin
          // ACK is checked first so it wins over a coincident timeout.
          if (ack_s) begin
            REQ_O <= 1'b0;
            state <= REQ_LOW;
          end else if (timeout_hit) begin
            REQ_O     <= 1'b0;
            TIMEOUT_O <= 1'b1;
            timed_out <= 1'b1;
            state     <= REQ_LOW;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        REQ_LOW: begin
          // No timeout here: the destination must always release ACK.
          if (!ack_s) begin
            DONE_O <= !timed_out;
            state  <= IDLE;
          end
        end
        default: begin
          REQ_O <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
module tb_cdc_handshake_tx;

  localparam int DW = 32;
  localparam int S  = 2;
  localparam int T  = 16;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          SEND_I = 1'b0;
  logic [DW-1:0] DATA_I = '0;
  logic          READY_O, REQ_O, DONE_O, TIMEOUT_O, DROP_O;
  logic [DW-1:0] DATA_O;
  logic          ack_man = 1'b0;
  logic          ack_resp = 1'b0;
  logic          resp_en = 1'b0;
  logic          ack_line;

  assign ack_line = resp_en ? ack_resp : ack_man;

  cdc_handshake_tx #(
    .DATA_WIDTH(DW), .SYNC_STAGES(S), .TIMEOUT_CYCLES(T)
  ) dut (
    .CLK(CLK), .RESET(RESET), .SEND_I(SEND_I), .DATA_I(DATA_I),
    .READY_O(READY_O), .REQ_O(REQ_O), .DATA_O(DATA_O),
    .ACK_ASYNC_I(ack_line), .DONE_O(DONE_O), .TIMEOUT_O(TIMEOUT_O),
    .DROP_O(DROP_O)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- transfer-level reference model ----------------
  // A transfer is "in flight" from acceptance until ACK has been seen
  // released; the synchronizer is just a S-edge delay of the ACK samples.
  bit            m_busy, m_acked, m_tout;
  int            m_elapsed;
  logic          m_req, m_done, m_to, m_drop;
  logic [DW-1:0] m_data;
  bit            ackq[$];

  task automatic model_reset();
    m_busy = 0; m_acked = 0; m_tout = 0; m_elapsed = 0;
    m_req = 0; m_done = 0; m_to = 0; m_drop = 0; m_data = '0;
    ackq.delete();
    repeat (S) ackq.push_back(1'b0);
  endtask

  task automatic model_edge();
    bit a_s;
    a_s = ackq.pop_front();
    ackq.push_back(ack_line);
    m_done = 0; m_to = 0;
    m_drop = SEND_I && m_busy;
    if (!m_busy) begin
      if (SEND_I) begin
        m_busy = 1; m_acked = 0; m_tout = 0; m_elapsed = 0;
        m_data = DATA_I; m_req = 1;
      end
    end else if (!m_acked) begin
      if (a_s) begin
        m_acked = 1; m_req = 0;
      end else if (T != 0 && m_elapsed == T - 1) begin
        m_acked = 1; m_tout = 1; m_req = 0; m_to = 1;
      end else begin
        m_elapsed++;
      end
    end else if (!a_s) begin
      m_busy = 0;
      m_done = !m_tout;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK or posedge RESET);
      if (RESET) model_reset();
      else       model_edge();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge CLK);
      chk("ready",   READY_O,   !m_busy);
      chk("req",     REQ_O,     m_req);
      chk("data",    DATA_O,    m_data);
      chk("done",    DONE_O,    m_done);
      chk("timeout", TIMEOUT_O, m_to);
      chk("drop",    DROP_O,    m_drop);
    end
  end

  // ---------------- random destination responder ----------------
  initial begin
    int rp, cnt;
    rp = 0; cnt = 0;
    forever begin
      @(negedge CLK);
      if (resp_en) begin
        case (rp)
          0: begin
            ack_resp = 1'b0;
            if (REQ_O) begin cnt = $urandom_range(0, 20); rp = 1; end
          end
          1: begin
            if (!REQ_O) rp = 0;
            else if (cnt == 0) begin ack_resp = 1'b1; rp = 2; end
            else cnt--;
          end
          2: if (!REQ_O) begin cnt = $urandom_range(0, 6); rp = 3; end
          default: begin
            if (cnt == 0) begin ack_resp = 1'b0; rp = 0; end
            else cnt--;
          end
        endcase
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_neg(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send(input logic [DW-1:0] d);
    SEND_I = 1'b1; DATA_I = d;
    wait_neg(1);
    SEND_I = 1'b0;
  endtask

  // Called with REQ_O high; returns at the negedge where DONE_O is high.
  task automatic finish_xfer(input int ackdly, input int reldly);
    wait_neg(ackdly);
    ack_man = 1'b1;
    for (int i = 0; i < 10 && REQ_O !== 1'b0; i++) wait_neg(1);
    chk("xfer_req_fall", REQ_O, 1'b0);
    wait_neg(reldly);
    ack_man = 1'b0;
    for (int i = 0; i < 10 && DONE_O !== 1'b1; i++) wait_neg(1);
    chk("xfer_done", DONE_O, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    wait_neg(3);
    chk("rst_req", REQ_O, 1'b0);
    chk("rst_data", DATA_O, '0);
    chk("rst_done", DONE_O, 1'b0);
    chk("rst_timeout", TIMEOUT_O, 1'b0);
    chk("rst_drop", DROP_O, 1'b0);
    #2 RESET = 1'b0;
    wait_neg(1);
    chk("ready_after_reset", READY_O, 1'b1);

    // basic transfer
    send(32'hA5A5_0001);
    chk("basic_req_lat1", REQ_O, 1'b1);
    chk("basic_model_req", m_req, 1'b1);
    chk("basic_model_data", m_data, 32'hA5A5_0001);
    wait_neg(2);
    ack_man = 1'b1;
    wait_neg(2);
    chk("basic_req_hold", REQ_O, 1'b1);
    wait_neg(1);
    chk("basic_req_fall_3", REQ_O, 1'b0);
    chk("basic_data", DATA_O, 32'hA5A5_0001);
    wait_neg(2);
    ack_man = 1'b0;
    wait_neg(2);
    chk("basic_done_early", DONE_O, 1'b0);
    wait_neg(1);
    chk("basic_done_3", DONE_O, 1'b1);
    chk("basic_ready_in_done", READY_O, 1'b1);
    chk("basic_data_end", DATA_O, 32'hA5A5_0001);
    wait_neg(1);
    chk("basic_done_single", DONE_O, 1'b0);

    // back-to-back: new SEND in the DONE cycle
    send(32'h1);
    finish_xfer(1, 1);
    send(32'h2);
    chk("b2b_req", REQ_O, 1'b1);
    chk("b2b_data", DATA_O, 32'h2);
    chk("b2b_nodrop", DROP_O, 1'b0);
    finish_xfer(2, 1);
    wait_neg(1);

    // overrun while REQ_HIGH
    send(32'h10);
    send(32'h3);
    chk("ovr_drop", DROP_O, 1'b1);
    chk("ovr_data_kept", DATA_O, 32'h10);
    finish_xfer(2, 2);
    wait_neg(1);
    chk("ovr_done_single", DONE_O, 1'b0);
    chk("ovr_data_end", DATA_O, 32'h10);

    // timeout, ACK never asserted
    send(32'h44);
    wait_neg(T - 1);
    chk("to_req_hold", REQ_O, 1'b1);
    wait_neg(1);
    chk("to_req_fall", REQ_O, 1'b0);
    chk("to_pulse", TIMEOUT_O, 1'b1);
    for (int i = 0; i < 3 && READY_O !== 1'b1; i++) wait_neg(1);
    chk("to_ready", READY_O, 1'b1);
    chk("to_no_done", DONE_O, 1'b0);
    wait_neg(2);

    // ACK synchronized exactly in the final counter cycle
    send(32'h55);
    wait_neg(T - 3);
    ack_man = 1'b1;
    wait_neg(2);
    chk("coin_req_hold", REQ_O, 1'b1);
    wait_neg(1);
    chk("coin_req_fall", REQ_O, 1'b0);
    chk("coin_no_timeout", TIMEOUT_O, 1'b0);
    wait_neg(1);
    ack_man = 1'b0;
    wait_neg(3);
    chk("coin_done", DONE_O, 1'b1);
    wait_neg(1);

    // async reset mid-transfer
    send(32'h66);
    wait_neg(2);
    #2 RESET = 1'b1;
    #1;
    chk("rstmid_req", REQ_O, 1'b0);
    chk("rstmid_data", DATA_O, '0);
    @(negedge CLK);
    #2 RESET = 1'b0;
    wait_neg(1);
    chk("rstmid_ready", READY_O, 1'b1);
    send(32'h77);
    chk("rstmid_new_req", REQ_O, 1'b1);
    finish_xfer(3, 2);
    wait_neg(2);

    // randomized traffic against the responder
    resp_en = 1'b1;
    repeat (600) begin
      @(negedge CLK);
      SEND_I = ($urandom_range(0, 3) == 0);
      DATA_I = $urandom();
    end
    @(negedge CLK);
    SEND_I = 1'b0;
    wait_neg(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
